// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Package : spi_pkg
// Brief   : Shared frame size and FSM state encoding for the SPI bus arbiter.
// Rev     : 1.0 - initial release
// ============================================================================
package spi_pkg;

   localparam int SPI_FRAME_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_SHIFT_HI = 3'd2,
      ST_SHIFT_LO = 3'd3,
      ST_GAP      = 3'd4
   } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : spi_bus_arbiter_if
// Brief     : Requester handshake plus board-level SPI pins of the arbiter.
// Rev       : 1.0 - initial release
// ============================================================================
interface spi_bus_arbiter_if
   import spi_pkg::*;
#(
   parameter int NUM_REQ = 2
);

   logic [NUM_REQ-1:0]                req;
   logic [SPI_FRAME_BITS*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]                grant;
   logic                              busy;
   logic                              done;
   logic [SPI_FRAME_BITS-1:0]         rx_data;
   logic                              sclk;
   logic [NUM_REQ-1:0]                cs_n;
   logic                              mosi;
   logic                              miso;

   modport master (
      input  req, req_data, miso,
      output grant, busy, done, rx_data, sclk, cs_n, mosi
   );

   modport slave (
      output req, req_data, miso,
      input  grant, busy, done, rx_data, sclk, cs_n, mosi
   );

endinterface
`default_nettype wire

// File: rtl/spi_bus_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick, first request at or above rr_ptr.
// Rev    : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import spi_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   output logic [NUM_REQ-1:0]         gnt_onehot,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
   output logic                       gnt_valid
);

   localparam int IDX_W = $clog2(NUM_REQ);

   int cand;

   // Scan offsets from the far end down so the smallest offset is written last and wins.
   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      gnt_valid  = 1'b0;
      cand       = 0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         cand = int'(rr_ptr) + off;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (req[cand[IDX_W-1:0]]) begin
            gnt_onehot                    = '0;
            gnt_onehot[cand[IDX_W-1:0]]   = 1'b1;
            gnt_idx                       = cand[IDX_W-1:0];
            gnt_valid                     = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : spi_bus_arbiter
// Brief  : Round-robin sharing of one mode-0 SPI master among NUM_REQ requesters.
// Rev    : 1.0 - initial release
// ============================================================================
module spi_bus_arbiter
   import spi_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int CLK_DIV = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   spi_bus_arbiter_if.master       bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_W = $clog2(SPI_FRAME_BITS + 1);

   spi_state_e                state_q, state_d;
   logic [DIV_W-1:0]          div_q, div_d;
   logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
   logic [SPI_FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
   logic [SPI_FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
   logic [SPI_FRAME_BITS-1:0] rx_data_q, rx_data_d;
   logic [NUM_REQ-1:0]        grant_q, grant_d;
   logic [NUM_REQ-1:0]        cs_n_q, cs_n_d;
   logic [IDX_W-1:0]          owner_q, owner_d;
   logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
   logic                      sclk_q, sclk_d;
   logic                      mosi_q, mosi_d;
   logic                      done_q, done_d;
   logic                      busy_q, busy_d;

   logic [NUM_REQ-1:0]        arb_onehot;
   logic [IDX_W-1:0]          arb_idx;
   logic                      arb_valid;
   logic                      div_last;
   logic [SPI_FRAME_BITS-1:0] req_bytes [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_bytes[i] = bus.req_data[i*SPI_FRAME_BITS +: SPI_FRAME_BITS];
   end

   rr_arbiter #(
      .NUM_REQ    (NUM_REQ)
   ) u_rr_arbiter (
      .req        (bus.req),
      .rr_ptr     (rr_ptr_q),
      .gnt_onehot (arb_onehot),
      .gnt_idx    (arb_idx),
      .gnt_valid  (arb_valid)
   );

   assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

   always_comb begin
      state_d    = state_q;
      div_d      = (state_q == ST_IDLE || div_last) ? '0 : div_q + 1'b1;
      bit_cnt_d  = bit_cnt_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      grant_d    = grant_q;
      cs_n_d     = cs_n_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               state_d    = ST_SETUP;
               grant_d    = arb_onehot;
               cs_n_d     = ~arb_onehot;
               owner_d    = arb_idx;
               tx_shift_d = req_bytes[arb_idx];
               mosi_d     = req_bytes[arb_idx][SPI_FRAME_BITS-1];
               bit_cnt_d  = '0;
            end
         end
         ST_SETUP: begin
            if (div_last) begin
               state_d    = ST_SHIFT_HI;
               sclk_d     = 1'b1;
               rx_shift_d = {rx_shift_q[SPI_FRAME_BITS-2:0], bus.miso};
            end
         end
         ST_SHIFT_HI: begin
            // Falling sclk: present the next bit so it is settled a full half-period before the rise.
            if (div_last) begin
               state_d    = ST_SHIFT_LO;
               sclk_d     = 1'b0;
               tx_shift_d = tx_shift_q << 1;
               mosi_d     = tx_shift_q[SPI_FRAME_BITS-2];
               bit_cnt_d  = bit_cnt_q + 1'b1;
            end
         end
         ST_SHIFT_LO: begin
            if (div_last) begin
               if (bit_cnt_q == CNT_W'(SPI_FRAME_BITS)) begin
                  state_d   = ST_GAP;
                  cs_n_d    = '1;
                  grant_d   = '0;
                  done_d    = 1'b1;
                  rx_data_d = rx_shift_q;
                  mosi_d    = 1'b0;
                  rr_ptr_d  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
               end else begin
                  state_d    = ST_SHIFT_HI;
                  sclk_d     = 1'b1;
                  rx_shift_d = {rx_shift_q[SPI_FRAME_BITS-2:0], bus.miso};
               end
            end
         end
         ST_GAP: begin
            if (div_last) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         div_q      <= '0;
         bit_cnt_q  <= '0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         grant_q    <= '0;
         cs_n_q     <= '1;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         grant_q    <= grant_d;
         cs_n_q     <= cs_n_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.grant   = grant_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rx_data = rx_data_q;
   assign bus.sclk    = sclk_q;
   assign bus.cs_n    = cs_n_q;
   assign bus.mosi    = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_bus_arbiter
// Brief  : Three arbiters (CLK_DIV 2, 1, 5) with mode-0 slave models and a frame-level reference.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_spi_bus_arbiter;
   import spi_pkg::*;

   localparam int N = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   int   mptr [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [2:0][N-1:0]        tb_req  = '0;
   logic [2:0][8*N-1:0]      tb_data = '0;
   logic [2:0][N-1:0][7:0]   slv_tx  = '0;
   wire  [2:0][N-1:0]        o_grant;
   wire  [2:0][N-1:0]        o_cs_n;
   wire  [2:0]               o_busy;
   wire  [2:0]               o_done;
   wire  [2:0]               o_sclk;
   wire  [2:0]               o_mosi;
   wire  [2:0][7:0]          o_rx;
   wire  [2:0][7:0]          o_slv_rx;

   for (genvar k = 0; k < 3; k++) begin : g_inst
      localparam int D = (k == 0) ? 2 : ((k == 1) ? 1 : 5);
      logic         miso_l    = 1'b0;
      logic [7:0]   sh        = 8'h00;
      logic [7:0]   rxb       = 8'h00;
      logic [N-1:0] cs_prev   = '1;
      logic         sclk_prev = 1'b0;

      spi_bus_arbiter_if #(.NUM_REQ(N)) bus ();

      assign bus.req      = tb_req[k];
      assign bus.req_data = tb_data[k];
      assign bus.miso     = miso_l;
      assign o_grant[k]   = bus.grant;
      assign o_cs_n[k]    = bus.cs_n;
      assign o_busy[k]    = bus.busy;
      assign o_done[k]    = bus.done;
      assign o_sclk[k]    = bus.sclk;
      assign o_mosi[k]    = bus.mosi;
      assign o_rx[k]      = bus.rx_data;
      assign o_slv_rx[k]  = rxb;

      spi_bus_arbiter #(.NUM_REQ(N), .CLK_DIV(D)) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      // Mode-0 slave: load on CS fall, sample mosi on sclk rise, shift on sclk fall.
      always begin
         @(posedge clk);
         #1;
         if (bus.cs_n == '1) begin
            miso_l = 1'b0;
         end else begin
            for (int s = 0; s < N; s++) begin
               if (cs_prev[s] && !bus.cs_n[s]) begin
                  sh  = slv_tx[k][s];
                  rxb = 8'h00;
               end
            end
            if (cs_prev == bus.cs_n && sclk_prev && !bus.sclk) sh = {sh[6:0], 1'b0};
            if (!sclk_prev && bus.sclk) rxb = {rxb[6:0], bus.mosi};
            miso_l = sh[7];
         end
         cs_prev   = bus.cs_n;
         sclk_prev = bus.sclk;
      end
   end

   function automatic int div_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
   endfunction

   function automatic int pick(input logic [N-1:0] m, input int p);
      for (int o = 0; o < N; o++) begin
         if (m[(p + o) % N]) return (p + o) % N;
      end
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tb_req = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) mptr[k] = 0;
   endtask

   // Observe one whole frame on instance k and compare it with the frame-level expectation.
   task automatic run_frame(input int k, input int exp_idx, input logic [7:0] exp_tx,
                            input logic [7:0] exp_rx, input int t_grant, input int drop_after,
                            input bit keep_req, output int done_at);
      int d, g_edge, done_edge, done_cnt, cs_low, rises, cs_bad, limit;
      logic [7:0] mbits;
      logic sp;
      d = div_of(k);
      g_edge = -1; done_edge = -1; done_cnt = 0; cs_low = 0; rises = 0; cs_bad = 0;
      mbits = 8'h00; sp = 1'b0;
      limit = cyc + 20*d + 40;
      while (cyc < limit && !(done_edge >= 0 && cyc >= done_edge + d)) begin
         @(posedge clk);
         #1;
         if (g_edge < 0 && o_grant[k] != '0) begin
            g_edge = cyc;
            check("grant_onehot", 32'(o_grant[k]), 32'(1 << exp_idx));
            check("busy_at_grant", 32'(o_busy[k]), 32'd1);
            if (t_grant >= 0) check("grant_time", cyc, t_grant);
         end
         if (o_cs_n[k] !== ~o_grant[k]) cs_bad++;
         if (o_cs_n[k] != '1) cs_low++;
         if (o_sclk[k] && !sp) begin
            rises++;
            mbits = {mbits[6:0], o_mosi[k]};
         end
         sp = o_sclk[k];
         if (o_done[k]) begin
            done_cnt++;
            if (done_edge < 0) begin
               done_edge = cyc;
               check("rx_data", 32'(o_rx[k]), 32'(exp_rx));
               check("slave_rx", 32'(o_slv_rx[k]), 32'(exp_tx));
               check("grant_clear_at_done", 32'(o_grant[k]), 32'd0);
               if (!keep_req) tb_req[k] = '0;
            end
         end
         if (g_edge >= 0 && drop_after >= 0 && cyc == g_edge + drop_after) tb_req[k][exp_idx] = 1'b0;
      end
      check("frame_completed", 32'(g_edge >= 0 && done_edge >= 0), 32'd1);
      check("done_latency", done_edge - g_edge, 17*d);
      check("cs_low_cycles", cs_low, 17*d);
      check("sclk_rises", rises, 8);
      check("mosi_bits", 32'(mbits), 32'(exp_tx));
      check("done_pulses", done_cnt, 1);
      check("cs_matches_grant", cs_bad, 0);
      done_at = done_edge;
      mptr[k] = (exp_idx + 1) % N;
   endtask

   initial begin
      int t, idx, dn, rises, dones;
      logic [N-1:0] m;
      for (int k = 0; k < 3; k++) mptr[k] = 0;

      do_reset();
      check("rst_grant", 32'(o_grant[0]), 32'd0);
      check("rst_cs_n",  32'(o_cs_n[0]),  32'(2'b11));
      check("rst_busy",  32'(o_busy[0]),  32'd0);
      check("rst_done",  32'(o_done[0]),  32'd0);
      check("rst_rx",    32'(o_rx[0]),    32'd0);
      check("rst_sclk",  32'(o_sclk[0]),  32'd0);
      check("rst_mosi",  32'(o_mosi[0]),  32'd0);

      // Single request, A5 out, 3C back.
      slv_tx[0][0] = 8'h3C;
      tb_data[0][7:0] = 8'hA5;
      tb_req[0] = 2'b01;
      t = cyc + 1;
      run_frame(0, 0, 8'hA5, 8'h3C, t, -1, 1'b0, dn);

      // Both requesting, four frames, alternating owners and back-to-back grants.
      repeat (4) @(posedge clk);
      do_reset();
      slv_tx[0][0] = 8'h11;
      slv_tx[0][1] = 8'h22;
      tb_data[0] = 16'h5AC3;
      tb_req[0] = 2'b11;
      t = cyc + 1;
      for (int f = 0; f < 4; f++) begin
         idx = pick(2'b11, mptr[0]);
         check("fair_order", idx, f % 2);
         run_frame(0, idx, tb_data[0][8*idx +: 8], slv_tx[0][idx], t, -1, (f != 3), dn);
         t = dn + div_of(0) + 1;
      end

      // Early drop of the request does not abort the frame.
      repeat (3) @(posedge clk);
      #1;
      tb_data[0][7:0] = 8'h96;
      slv_tx[0][0] = 8'h69;
      tb_req[0] = 2'b01;
      idx = pick(2'b01, mptr[0]);
      run_frame(0, idx, 8'h96, 8'h69, cyc + 1, 3, 1'b0, dn);

      // Randomised traffic against the round-robin reference.
      for (int f = 0; f < 10; f++) begin
         m = N'($urandom_range(1, 3));
         tb_data[0] = 16'($urandom);
         slv_tx[0][0] = 8'($urandom);
         slv_tx[0][1] = 8'($urandom);
         idx = pick(m, mptr[0]);
         tb_req[0] = m;
         run_frame(0, idx, tb_data[0][8*idx +: 8], slv_tx[0][idx], cyc + 1, -1, 1'b0, dn);
      end

      // Reset in the middle of a frame.
      tb_data[0] = 16'hC35A;
      tb_req[0] = 2'b10;
      rises = 0;
      for (int c = 0; c < 200 && rises < 4; c++) begin
         @(posedge clk);
         #1;
         if (o_sclk[0] && !g_inst[0].sclk_prev) rises++;
      end
      check("mid_rises_reached", rises, 4);
      rst = 1'b1;
      tb_req[0] = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) mptr[k] = 0;
      check("mid_rst_sclk",  32'(o_sclk[0]),  32'd0);
      check("mid_rst_cs_n",  32'(o_cs_n[0]),  32'(2'b11));
      check("mid_rst_busy",  32'(o_busy[0]),  32'd0);
      check("mid_rst_rx",    32'(o_rx[0]),    32'd0);
      check("mid_rst_grant", 32'(o_grant[0]), 32'd0);
      dones = 0;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk);
         #1;
         if (o_done[0]) dones++;
      end
      check("no_done_after_rst", dones, 0);
      slv_tx[0][0] = 8'hE7;
      tb_data[0] = 16'h0F18;
      tb_req[0] = 2'b11;
      idx = pick(2'b11, mptr[0]);
      run_frame(0, idx, tb_data[0][8*idx +: 8], slv_tx[0][idx], cyc + 1, -1, 1'b0, dn);

      // Divider sweep: all-ones and all-zeros in both directions.
      for (int k = 1; k < 3; k++) begin
         slv_tx[k][0] = 8'h00;
         slv_tx[k][1] = 8'hFF;
         tb_data[k] = 16'h00FF;
         tb_req[k] = 2'b01;
         idx = pick(2'b01, mptr[k]);
         run_frame(k, idx, 8'hFF, 8'h00, cyc + 1, -1, 1'b0, dn);
         repeat (2) @(posedge clk);
         #1;
         tb_req[k] = 2'b10;
         idx = pick(2'b10, mptr[k]);
         run_frame(k, idx, 8'h00, 8'hFF, cyc + 1, -1, 1'b0, dn);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Shares one SPI bus (mode 0, MSB-first, 8-bit frames) between `NUM_REQ` local requesters, each owning one slave select line. The block runs the round-robin arbitration and generates `sclk` from the system clock. It drives the per-slave active-low chip selects, shifts the granted requester's byte out on `mosi`, and captures the slave's reply from `miso`. It sits between on-chip requesters and the board-level SPI slaves, which load their TX byte on chip-select fall, sample on `sclk` rise and shift on `sclk` fall.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters and chip selects; legal range 2..8.
- `CLK_DIV`, default 2: `clk` cycles per `sclk` half-period; must be ≥ 1.

Ports:
- `clk`, input, 1: system clock. All logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, `NUM_REQ`: level request. Hold high until `done` for that requester.
- `req_data`, input, `8*NUM_REQ`: TX byte per requester. Byte i is `[8i+7:8i]`.
- `grant`, output, `NUM_REQ`: one-hot, marks the current owner. High from the grant cycle through `done`.
- `busy`, output, 1: high whenever the state is not IDLE.
- `done`, output, 1: one-cycle pulse at the end of a frame.
- `rx_data`, output, 8: byte received from the slave. Updated in the `done` cycle and held afterwards.
- `sclk`, output, 1: SPI clock. Idles low.
- `cs_n`, output, `NUM_REQ`: active-low selects. At most one bit is low at any time.
- `mosi`, output, 1: serial data to the slaves.
- `miso`, input, 1: serial data from the selected slave.

## Operation
- States are IDLE → SETUP → SHIFT_HI ↔ SHIFT_LO → GAP → IDLE.
- IDLE, with any `req` bit high: choose the first requester at or after `rr_ptr`, searching upward with wrap-around. On the next edge:
  - assert `grant[i]` and drive `cs_n[i]` low;
  - latch `req_data[i]` into `tx_shift`;
  - drive `mosi` to bit 7;
  - clear `bit_cnt`;
  - move to SETUP.
- SETUP lasts `CLK_DIV` cycles with `sclk` low, which gives the slave its CS-to-clock setup time.
- SHIFT_HI lasts `CLK_DIV` cycles with `sclk` high. On entry, shift the current `miso` value into `rx_shift` at the LSB.
- SHIFT_LO lasts `CLK_DIV` cycles with `sclk` low. On entry:
  - shift `tx_shift` left and drive the new MSB onto `mosi`;
  - increment `bit_cnt`.
- The frame is 8 SHIFT_HI/SHIFT_LO pairs. After the 8th SHIFT_LO the block moves to GAP.
- On entry to GAP, in a single cycle:
  - `cs_n` returns to all ones;
  - `grant` returns to 0;
  - `done` = 1;
  - `rx_data` ← `rx_shift`;
  - `mosi` = 0;
  - `rr_ptr` ← (i+1) mod `NUM_REQ`.
- GAP holds for `CLK_DIV` cycles with CS high, so the slave sees a deselect between frames. It then returns to IDLE.
- `req` and `req_data` are ignored while a frame is in flight. A requester that drops `req` early does not abort its frame.
- A requester that keeps `req` high after its `done` competes again under round-robin.
- Reset values, applied at the first edge with `rst` high regardless of state, including mid-frame: `sclk` = 0, `cs_n` = all ones, `mosi` = 0, `grant` = 0, `busy` = 0, `done` = 0, `rx_data` = 0, `rr_ptr` = 0, state = IDLE. A frame interrupted by reset is lost and produces no `done`.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Counting a request seen in IDLE at cycle T:
  - `grant` and `cs_n` change at T+1;
  - the first `sclk` rise is at T+1+`CLK_DIV`;
  - `done` is at T+1+17·`CLK_DIV`;
  - the next grant is possible no earlier than T+2+18·`CLK_DIV` (GAP plus one IDLE cycle).
- With `CLK_DIV`=2: `done` at T+35.
- Bit k (7 = MSB) of `mosi` is stable for at least `CLK_DIV` cycles before the matching `sclk` rise.
- `miso` is sampled at the `clk` edge that raises `sclk`. The slave has changed `miso` at least `CLK_DIV` cycles earlier, on the previous `sclk` fall or at CS fall.
- A request that arrives in the same cycle as `done` is not served until IDLE.

## Structure
- Shared package `spi_pkg`:
  - state enum (`ST_IDLE`, `ST_SETUP`, `ST_SHIFT_HI`, `ST_SHIFT_LO`, `ST_GAP`);
  - `SPI_FRAME_BITS` = 8.
- One sub-module: `rr_arbiter` (combinational round-robin pick from `req` and `rr_ptr`, producing a one-hot result and an index). The arbiter's FSM, divider counter and shift registers stay in the top level.

## Test plan
- Single request: `req`=01, `req_data[7:0]`=0xA5, slave TX byte 0x3C, `CLK_DIV`=2 → `cs_n`=10 for exactly 34 cycles; `mosi` shows 1,0,1,0,0,1,0,1 at the 8 `sclk` rises; `done` at T+35 with `rx_data`=0x3C.
- Simultaneous requests: `req`=11 held, `rr_ptr`=0 → requester 0 is served first, then requester 1. The two `cs_n` low windows never overlap, and at least `CLK_DIV`+1 cycles of all-high `cs_n` separate them.
- Fairness: `req`=11 held for 4 frames → grant order is 0,1,0,1. Each `done` returns the correct slave's byte (0x11 from slave 0, 0x22 from slave 1).
- Early drop: `req`=01 deasserted 3 cycles after grant → the full 8-bit frame completes and `done` pulses once.
- Reset mid-frame: `rst` high after the 4th `sclk` rise → the next edge gives `sclk`=0, `cs_n`=all ones, `busy`=0, `rx_data`=0, and no `done`. A fresh request afterwards completes normally.
- Divider sweep: `CLK_DIV`=1 and `CLK_DIV`=5, with 0xFF and 0x00 exchanged → correct data in both directions, and `done` at T+18 and T+86 respectively.
